clock_divider_bank: RTL and testbench

Multi-channel, runtime-programmable successor to the fixed-prescaler clock divider. It generates CH independent divided outputs from one system clock. Each channel has its own divisor, per-channel enable and a pulse or 50%-duty square mode. Divisor and mode updates are glitch-free: they are staged in a shadow register and applied only at the channel's terminal count. The bank feeds display multiplexing, debounce sampling and BCD counter stepping on the Basys 3 design; all outputs are used as enables in the clk_i domain, not as clocks.

---
 rtl/clock_divider_bank_if.sv | 32 +++
 rtl/clock_divider_bank.sv | 107 ++++++++++
 tb/tb_clock_divider_bank.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_bank_if
// Brief    : Enable / configuration / output bundle for clock_divider_bank.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_divider_bank_if #(
    parameter int CH    = 4,
    parameter int WIDTH = 16
);
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]    en_i;
    logic             wr_en_i;
    logic [SEL_W-1:0] wr_sel_i;
    logic [WIDTH-1:0] wr_div_i;
    logic             wr_mode_i;
    logic [CH-1:0]    tick_o;
    logic [CH-1:0]    clk_o;
    logic [CH-1:0]    busy_o;

    modport master (
        output en_i, wr_en_i, wr_sel_i, wr_div_i, wr_mode_i,
        input  tick_o, clk_o, busy_o
    );

    modport slave (
        input  en_i, wr_en_i, wr_sel_i, wr_div_i, wr_mode_i,
        output tick_o, clk_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_bank
// Brief    : CH independent programmable dividers with shadowed, glitch-free
//            divisor/mode updates applied at terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_bank #(
    parameter int CH      = 4,
    parameter int WIDTH   = 16,
    parameter int DEF_DIV = 100
) (
    input  wire logic             clk_i,
    input  wire logic             clr_i,
    clock_divider_bank_if.slave   bus
);
    localparam int               SEL_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [WIDTH-1:0] C_DEF = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [CH-1:0] w_tick;
    logic [CH-1:0] w_clk;
    logic [CH-1:0] w_busy;

    generate
        for (genvar n = 0; n < CH; n++) begin : g_ch
            logic [WIDTH-1:0] r_cnt;
            logic [WIDTH-1:0] r_div;
            logic [WIDTH-1:0] r_sh_div;
            logic             r_mode;
            logic             r_sh_mode;
            logic             r_pend;
            logic             r_tick;
            logic             r_clk;
            logic             w_en;
            logic             w_wr;
            logic             w_wrap;
            logic             w_half;
            logic [WIDTH-1:0] w_wr_div;

            assign w_en     = bus.en_i[n];
            assign w_wr     = bus.wr_en_i && (bus.wr_sel_i == SEL_W'(n));
            assign w_wrap   = (r_cnt == r_div - C_ONE);
            // Last count of the high phase: ceil(D/2)-1 == (D-1)>>1
            assign w_half   = (r_cnt == ((r_div - C_ONE) >> 1));
            assign w_wr_div = (bus.wr_div_i == '0) ? C_ONE : bus.wr_div_i;

            always_ff @(posedge clk_i) begin
                if (clr_i) begin
                    r_cnt     <= '0;
                    r_div     <= C_DEF;
                    r_mode    <= 1'b0;
                    r_sh_div  <= C_DEF;
                    r_sh_mode <= 1'b0;
                    r_pend    <= 1'b0;
                    r_tick    <= 1'b0;
                    r_clk     <= 1'b0;
                end else begin
                    if (r_pend && !w_en) begin
                        r_cnt  <= '0;
                        r_div  <= r_sh_div;
                        r_mode <= r_sh_mode;
                        r_clk  <= 1'b0;
                        r_pend <= 1'b0;
                        r_tick <= 1'b0;
                    end else if (w_en) begin
                        if (w_wrap) begin
                            r_cnt  <= '0;
                            r_tick <= 1'b1;
                            // Rising edge follows the mode in force for the new period
                            r_clk  <= r_pend ? r_sh_mode : r_mode;
                            if (r_pend) begin
                                r_div  <= r_sh_div;
                                r_mode <= r_sh_mode;
                                r_pend <= 1'b0;
                            end
                        end else begin
                            r_cnt  <= r_cnt + C_ONE;
                            r_tick <= 1'b0;
                            if (r_mode && w_half) begin
                                r_clk <= 1'b0;
                            end
                        end
                    end else begin
                        r_tick <= 1'b0;
                    end

                    // A write on an apply edge lands after the apply and stays pending
                    if (w_wr) begin
                        r_sh_div  <= w_wr_div;
                        r_sh_mode <= bus.wr_mode_i;
                        r_pend    <= 1'b1;
                    end
                end
            end

            assign w_tick[n] = r_tick;
            assign w_clk[n]  = r_clk;
            assign w_busy[n] = r_pend;
        end
    endgenerate

    assign bus.tick_o = w_tick;
    assign bus.clk_o  = w_clk;
    assign bus.busy_o = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_bank
// Brief    : Directed + random stimulus against a period/phase reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_bank;
    localparam int CH      = 5;
    localparam int WIDTH   = 16;
    localparam int DEF_DIV = 100;
    localparam int SEL_W   = (CH > 1) ? $clog2(CH) : 1;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    clock_divider_bank_if #(.CH(CH), .WIDTH(WIDTH)) bus ();

    clock_divider_bank #(
        .CH      (CH),
        .WIDTH   (WIDTH),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_i (clk),
        .clr_i (clr),
        .bus   (bus)
    );

    // Model: each channel is a position k within a period of D enabled edges.
    int m_div    [CH];
    int m_sh_div [CH];
    int m_k      [CH];
    bit m_sq     [CH];
    bit m_sh_sq  [CH];
    bit m_pend   [CH];
    bit m_started[CH];
    bit m_tick   [CH];

    int checks = 0;
    int errors = 0;

    function automatic void model_edge();
        for (int n = 0; n < CH; n++) begin
            if (clr) begin
                m_div[n] = DEF_DIV; m_sh_div[n] = DEF_DIV; m_k[n] = 0;
                m_sq[n] = 0; m_sh_sq[n] = 0; m_pend[n] = 0;
                m_started[n] = 0; m_tick[n] = 0;
            end else begin
                if (m_pend[n] && !bus.en_i[n]) begin
                    m_div[n] = m_sh_div[n]; m_sq[n] = m_sh_sq[n];
                    m_k[n] = 0; m_started[n] = 0; m_pend[n] = 0; m_tick[n] = 0;
                end else if (bus.en_i[n]) begin
                    m_tick[n] = (m_k[n] == m_div[n] - 1);
                    if (m_tick[n]) begin
                        m_k[n] = 0;
                        m_started[n] = 1;
                        if (m_pend[n]) begin
                            m_div[n] = m_sh_div[n]; m_sq[n] = m_sh_sq[n]; m_pend[n] = 0;
                        end
                    end else begin
                        m_k[n] = m_k[n] + 1;
                    end
                end else begin
                    m_tick[n] = 0;
                end
                if (bus.wr_en_i && int'(bus.wr_sel_i) == n) begin
                    m_sh_div[n] = (bus.wr_div_i == 0) ? 1 : int'(bus.wr_div_i);
                    m_sh_sq[n]  = bus.wr_mode_i;
                    m_pend[n]   = 1;
                end
            end
        end
    endfunction

    // Square output is high during the first ceil(D/2) positions of each period
    function automatic bit exp_clk_bit(int n);
        return m_sq[n] && m_started[n] && (m_k[n] < (m_div[n] + 1) / 2);
    endfunction

    task automatic compare();
        logic [CH-1:0] e_tick, e_clk, e_busy;
        for (int n = 0; n < CH; n++) begin
            e_tick[n] = m_tick[n];
            e_clk[n]  = exp_clk_bit(n);
            e_busy[n] = m_pend[n];
        end
        checks++;
        assert (bus.tick_o === e_tick) else begin
            errors++;
            $error("FAIL tick_o t=%0t observed=%b expected=%b", $time, bus.tick_o, e_tick);
        end
        checks++;
        assert (bus.clk_o === e_clk) else begin
            errors++;
            $error("FAIL clk_o t=%0t observed=%b expected=%b", $time, bus.clk_o, e_clk);
        end
        checks++;
        assert (bus.busy_o === e_busy) else begin
            errors++;
            $error("FAIL busy_o t=%0t observed=%b expected=%b", $time, bus.busy_o, e_busy);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic write(input int sel, input int div, input bit mode);
        bus.wr_en_i   = 1'b1;
        bus.wr_sel_i  = SEL_W'(sel);
        bus.wr_div_i  = WIDTH'(div);
        bus.wr_mode_i = mode;
        step();
        bus.wr_en_i   = 1'b0;
    endtask

    initial begin
        bit found;
        clr           = 1'b1;
        bus.en_i      = '0;
        bus.wr_en_i   = 1'b0;
        bus.wr_sel_i  = '0;
        bus.wr_div_i  = '0;
        bus.wr_mode_i = 1'b0;
        for (int n = 0; n < CH; n++) begin
            m_div[n] = 0; m_sh_div[n] = 0; m_k[n] = 0; m_sq[n] = 0;
            m_sh_sq[n] = 0; m_pend[n] = 0; m_started[n] = 0; m_tick[n] = 0;
        end
        run(2);
        clr      = 1'b0;
        bus.en_i = '1;

        // Default cadence, then ch1 reprogrammed at cnt=3 to square 6 and 5
        run(3);
        write(1, 6, 1'b1);
        run(110);
        write(1, 5, 1'b1);
        run(20);
        write(1, 0, 1'b1);
        run(10);
        write(1, 1, 1'b1);
        run(10);
        write(1, 2, 1'b1);
        run(12);

        // ch2 disabled mid-count, written while disabled, then re-enabled
        write(2, 8, 1'b1);
        run(30);
        bus.en_i[2] = 1'b0;
        run(20);
        write(2, 10, 1'b1);
        run(3);
        bus.en_i[2] = 1'b1;
        run(25);

        // ch0: 7 then 9 before the wrap, 11 landing exactly on the wrap edge
        write(0, 7, 1'b0);
        run(5);
        write(0, 9, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_k[0] == m_div[0] - 1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        assert (found === 1'b1) else begin
            errors++;
            $error("FAIL ch0_wrap_search observed=%b expected=%b", found, 1'b1);
        end
        write(0, 11, 1'b1);
        run(30);

        // Reset while ch3 is busy and ch1 square is high
        write(3, 50, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (exp_clk_bit(1)) break;
            step();
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        run(3);
        write(CH, 3, 1'b1);
        write(7, 4, 1'b1);
        run(105);

        // Random traffic with small divisors
        for (int c = 0; c < 1500; c++) begin
            for (int n = 0; n < CH; n++) bus.en_i[n] = ($urandom_range(0, 7) != 0);
            bus.wr_en_i   = ($urandom_range(0, 7) == 0);
            bus.wr_sel_i  = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
            bus.wr_div_i  = WIDTH'($urandom_range(0, 12));
            bus.wr_mode_i = 1'($urandom_range(0, 1));
            clr           = ($urandom_range(0, 299) == 0);
            step();
        end
        clr         = 1'b0;
        bus.wr_en_i = 1'b0;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
